lc3_mem_seq: RTL and testbench
==============================

# lc3_mem_seq

Parametrised memory-access sequencer for the LC-3 datapath. It takes the memory sub-sequences of the control FSM (read, write, and the indirect pointer-then-data pairs used by LDI/STI) and runs them as one self-contained handshake. The control FSM issues one request and waits for `done`. The block adds wait-state tolerance, a bus-hang timeout with error reporting, and configurable data/address width.

## Interface
Parameters:
- `DATA_W`, 16: memory data width.
- `ADDR_W`, 16: memory address width; must satisfy `ADDR_W <= DATA_W`. Indirect pointers use `rdata[ADDR_W-1:0]`.
- `TIMEOUT`, 64: maximum cycles one access may wait for `READY`. 0 disables the timeout.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `CLK` in 1: clock.
  - `RESET` in 1: asynchronous, active-high reset.
- Request side (control FSM):
  - `req` in 1: start request; sampled only in IDLE.
  - `op` in 2: 00 READ, 01 WRITE, 10 READ_IND, 11 WRITE_IND.
  - `addr` in ADDR_W: access address (pointer address for the _IND ops).
  - `wdata` in DATA_W: write data.
  - `busy` out 1: high in every state except IDLE.
  - `done` out 1: one-cycle completion pulse.
  - `err` out 1: valid with `done`; 1 means the access was aborted by timeout.
  - `rdata` out DATA_W: read result, held until the next accepted request.
- Memory side:
  - `mem_addr` out ADDR_W: memory address.
  - `mem_wdata` out DATA_W: memory write data.
  - `CS` out 1: chip select.
  - `WE` out 1: write enable.
  - `mem_rdata` in DATA_W: memory read data.
  - `READY` in 1: memory completion.

## Operation
- States:
  - IDLE
  - PTR (pointer read)
  - ACC (data read or write)
  - FIN (done pulse)
- IDLE:
  - When `req`=1: latch `op`, `addr` and `wdata`, and clear the wait counter.
  - Next state is PTR for the _IND ops, otherwise ACC.
- PTR:
  - Drives `CS`=1, `WE`=0, `mem_addr`=latched addr.
  - On `READY`=1: latch `mem_rdata[ADDR_W-1:0]` as the new address, clear the wait counter, go to ACC.
- ACC:
  - Drives `CS`=1, `mem_addr`=current address.
  - `WE`=1 for WRITE/WRITE_IND, with `mem_wdata`=latched wdata.
  - On `READY`=1:
    - Read ops capture `mem_rdata` into `rdata`.
    - Go to FIN.
- FIN: `done`=1, `err` as recorded, then IDLE. `err` clears on the next accept.
- Wait counter:
  - Increments on each PTR/ACC cycle with `READY`=0.
  - If it reaches `TIMEOUT-1` with `READY` still 0, the cycle that follows aborts: set `err`, go to FIN, `rdata` unchanged.
- `READY` is ignored outside PTR/ACC.
- `req` is ignored while `busy`. No queueing.
- `mem_addr` and `mem_wdata` are stable for the whole time `CS` is high.
- Undriven outputs are 0. `CS` and `WE` are never high in IDLE or FIN.

## Timing
- Reset values: all outputs 0, state IDLE, `rdata`=0, wait counter=0.
- Reset mid-access: `CS` and `WE` drop asynchronously, no `done` is issued, and the in-flight request is discarded.
- Zero-wait READ/WRITE:
  - `req` accepted at cycle 0.
  - ACC at cycle 1.
  - `done` at cycle 2.
  - `req` can next be accepted at cycle 3.
- Each memory wait cycle adds 1. The _IND ops add 1 + pointer waits.
- Timeout: one access lasts at most `TIMEOUT` cycles in PTR/ACC. `done`/`err` come the cycle after.
- `READY` arriving on the final allowed cycle counts as success; timeout applies only to the cycle after.
- All outputs are registered-state decodes: Moore, no combinational path from `READY` or `req`.

## Structure
- `lc3_pkg` holds:
  - `mem_op_t` (READ, WRITE, READ_IND, WRITE_IND).
  - `mem_seq_state_t` (IDLE, PTR, ACC, FIN).
  - The 2-bit op encodings.
- One sub-module: `mem_wait_timer`.
  - Parameter `TIMEOUT`.
  - Inputs `clr`, `en`; output `expired`.
  - Counter width `$clog2(TIMEOUT+1)`.
  - When `TIMEOUT`=0, `expired` is tied to 0.
- Single next-state `always_comb` plus registered state and data latches.

## Test plan
1. READ addr=0x3000 with `READY` high on the first ACC cycle, `mem_rdata`=0x1234 → `CS` for 1 cycle, `done` at cycle 2, `rdata`=0x1234, `err`=0.
2. WRITE addr=0x4000 wdata=0xBEEF with 3 wait cycles → `CS`=`WE`=1 for 4 cycles, `mem_wdata`=0xBEEF throughout, `done` at cycle 5.
3. READ_IND addr=0x3001, pointer=0x5000, data=0x00AA, both zero-wait → second access at `mem_addr`=0x5000, `rdata`=0x00AA, `done` at cycle 3.
4. With `TIMEOUT`=4 and `READY` held low → `CS` high exactly 4 cycles, then `done`=1 `err`=1, `rdata` keeps its previous value.
5. `req` pulsed while busy, then `RESET` asserted mid-ACC → second `req` ignored; after reset `CS`=`WE`=0 immediately, no `done`, IDLE.
6. WRITE_IND with `READY` on the last allowed pointer cycle (`TIMEOUT`=4, 3 waits) → success, no `err`, write goes to the fetched pointer.

Source files
------------

// File: rtl/lc3_mem_seq_pkg.sv
// Shared types for the LC-3 memory-access sequencer: op encodings, op enum,
// sequencer state enum and small op-decoding helpers.
package lc3_pkg;

    localparam logic [1:0] OP_READ      = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_READ_IND  = 2'b10;
    localparam logic [1:0] OP_WRITE_IND = 2'b11;

    typedef enum logic [1:0] {
        MEM_READ      = OP_READ,
        MEM_WRITE     = OP_WRITE,
        MEM_READ_IND  = OP_READ_IND,
        MEM_WRITE_IND = OP_WRITE_IND
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PTR  = 2'd1,
        S_ACC  = 2'd2,
        S_FIN  = 2'd3
    } mem_seq_state_t;

    // Bit 1 selects the indirect forms, bit 0 selects the write forms.
    function automatic logic op_is_ind(input mem_op_t o);
        return o[1];
    endfunction

    function automatic logic op_is_write(input mem_op_t o);
        return o[0];
    endfunction

endpackage

// File: rtl/lc3_mem_seq_timer.sv
// Wait-state counter for one memory access; expired is high once TIMEOUT-1
// wait cycles have been counted, so the next unanswered cycle aborts.
module mem_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // Saturates at LAST; the sequencer leaves PTR/ACC on that cycle anyway.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en && (cnt_q != LAST)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/lc3_mem_seq.sv
// LC-3 memory-access sequencer: runs READ/WRITE and pointer-then-data indirect
// accesses as one request/done handshake with wait-state timeout.
module lc3_mem_seq
    import lc3_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req,
    input  logic [1:0]            op,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  CS,
    output logic                  WE,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  READY,
    output mem_seq_state_t        dbg_state
);

    mem_seq_state_t    state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              accept;
    logic              in_mem;
    logic              expired;

    assign in_mem = (state_q == S_PTR) || (state_q == S_ACC);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr     (accept || ((state_q == S_PTR) && READY)),
        .en      (in_mem && !READY),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    op_d    = mem_op_t'(op);
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    state_d = op_is_ind(mem_op_t'(op)) ? S_PTR : S_ACC;
                end
            end
            S_PTR: begin
                if (READY) begin
                    // The fetched pointer replaces the address for the data access.
                    addr_d  = mem_rdata[ADDR_W-1:0];
                    state_d = S_ACC;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_ACC: begin
                if (READY) begin
                    if (!op_is_write(op_q)) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_FIN;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            op_q    <= MEM_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Every output is a decode of registered state, so nothing depends on READY or req.
    assign CS        = in_mem;
    assign WE        = (state_q == S_ACC) && op_is_write(op_q);
    assign mem_addr  = in_mem ? addr_q : '0;
    assign mem_wdata = WE ? wdata_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = (state_q == S_FIN) && err_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lc3_mem_seq.sv
// Bench for lc3_mem_seq: directed and random requests against a word-level
// memory model, with a scoreboard checking each done pulse.
module tb_lc3_mem_seq;
    import lc3_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int TMO = 4;

    logic          CLK, RESET, req, busy, done, err, CS, WE, READY;
    logic [1:0]    op;
    logic [AW-1:0] addr, mem_addr;
    logic [DW-1:0] wdata, rdata, mem_wdata, mem_rdata;
    mem_seq_state_t dbg_state;

    lc3_mem_seq #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .CS(CS), .WE(WE),
        .mem_rdata(mem_rdata), .READY(READY), .dbg_state(dbg_state)
    );

    typedef struct {
        int            waits;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wd;
    } phase_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DW:0]   exp_q[$];
    int            exp_t_q[$];
    phase_t        ph_q[$];
    logic [DW-1:0] bus_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] rdata_m = '0;

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 16'd37 + 16'd11) & 16'h001F;
    endfunction

    function automatic logic [DW-1:0] bus_rd(input logic [AW-1:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // Reference model: each access phase lasts waits+1 cycles, or TMO cycles when
    // waits reach TMO (abort); done appears one cycle after the last phase.
    task automatic do_txn(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int pw, input int aw, input bit poke);
        logic          e;
        logic [AW-1:0] da;
        int            t_len;
        int            n;
        phase_t        ph;
        e = 1'b0;
        t_len = 1;
        da = a;
        if (o[1]) begin
            ph.waits = pw; ph.addr = a; ph.we = 1'b0; ph.wd = '0;
            ph_q.push_back(ph);
            if (pw >= TMO) begin
                e = 1'b1;
                t_len += TMO;
            end else begin
                t_len += pw + 1;
                da = ref_rd(a);
            end
        end
        if (!e) begin
            ph.waits = aw; ph.addr = da; ph.we = o[0]; ph.wd = o[0] ? wd : '0;
            ph_q.push_back(ph);
            if (aw >= TMO) begin
                e = 1'b1;
                t_len += TMO;
            end else begin
                t_len += aw + 1;
                if (o[0]) ref_mem[da] = wd;
                else      rdata_m = ref_rd(da);
            end
        end
        exp_q.push_back({e, rdata_m});
        exp_t_q.push_back(cyc + t_len);

        op = o; addr = a; wdata = wd; req = 1'b1;
        @(negedge CLK);
        n = 0;
        while (!done && n < 64) begin
            req = poke;
            @(negedge CLK);
            n++;
        end
        if (n >= 64) chk("done_timeout", 32'(n), 32'(t_len));
        req = poke;
        @(negedge CLK);
        req = 1'b0;
    endtask

    // ---------------- memory responder ----------------
    initial begin
        phase_t cur;
        int     left;
        bit     active;
        active = 1'b0;
        left = 0;
        READY = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge CLK);
            if (RESET || !CS) begin
                active = 1'b0;
                if (!RESET) begin
                    chk("we_without_cs", 32'(WE), 32'd0);
                    chk("addr_without_cs", 32'(mem_addr), 32'd0);
                end
                READY = 1'($urandom_range(0, 1));
                mem_rdata = DW'($urandom);
            end else begin
                if (!active) begin
                    if (ph_q.size() == 0) begin
                        chk("unexpected_access", 32'(mem_addr), 32'hFFFF_FFFF);
                        cur.waits = 0; cur.addr = mem_addr; cur.we = WE; cur.wd = mem_wdata;
                    end else begin
                        cur = ph_q.pop_front();
                    end
                    left = cur.waits;
                    active = 1'b1;
                end
                chk("bus_addr", 32'(mem_addr), 32'(cur.addr));
                chk("bus_we", 32'(WE), 32'(cur.we));
                chk("bus_wdata", 32'(mem_wdata), 32'(cur.wd));
                if (left > 0) begin
                    READY = 1'b0;
                    mem_rdata = DW'($urandom);
                    left--;
                end else begin
                    READY = 1'b1;
                    mem_rdata = bus_rd(mem_addr);
                    if (WE) bus_mem[mem_addr] = mem_wdata;
                    active = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [DW:0] e;
        int          t;
        forever begin
            @(negedge CLK);
            if (!RESET && done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    chk("done_err", 32'(err), 32'(e[DW]));
                    chk("done_rdata", 32'(rdata), 32'(e[DW-1:0]));
                    chk("done_cycle", 32'(cyc), 32'(t));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]    o;
        logic [DW-1:0] wd;
        RESET = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_cs_we", {30'd0, CS, WE}, 0);
        chk("rst_bus", {mem_addr, mem_wdata}, 0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        RESET = 1'b0;
        @(negedge CLK);

        preload(16'h3000, 16'h1234);
        do_txn(OP_READ, 16'h3000, 16'h0000, 0, 0, 1'b0);
        do_txn(OP_WRITE, 16'h4000, 16'hBEEF, 0, 3, 1'b0);
        preload(16'h3001, 16'h5000);
        preload(16'h5000, 16'h00AA);
        do_txn(OP_READ_IND, 16'h3001, 16'h0000, 0, 0, 1'b0);
        do_txn(OP_READ, 16'h4000, 16'h0000, 0, 10, 1'b0);
        preload(16'h3002, 16'h6000);
        do_txn(OP_WRITE_IND, 16'h3002, 16'h1357, 3, 0, 1'b0);
        do_txn(OP_READ, 16'h6000, 16'h0000, 2, 1, 1'b0);
        do_txn(OP_READ_IND, 16'h3001, 16'h0000, 10, 0, 1'b0);

        // req held high while busy: only the first request may run.
        do_txn(OP_READ, 16'h4000, 16'h0000, 0, 2, 1'b1);
        repeat (3) begin
            chk("poke_idle_busy", 32'(busy), 0);
            @(negedge CLK);
        end

        // Reset in the middle of a data access.
        ph_q.push_back('{waits: 50, addr: 16'h0010, we: 1'b0, wd: 16'h0000});
        op = OP_READ; addr = 16'h0010; req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        @(negedge CLK);
        chk("pre_rst_cs", 32'(CS), 1);
        #2 RESET = 1'b1;
        #1;
        chk("midrst_cs_we", {30'd0, CS, WE}, 0);
        chk("midrst_busy_done", {30'd0, busy, done}, 0);
        chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
        ph_q.delete();
        rdata_m = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_rdata", 32'(rdata), 0);

        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            wd = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 31));
            do_txn(o, AW'($urandom_range(0, 31)), wd,
                   $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (5) @(negedge CLK);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("phase_q_drained", 32'(ph_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
